// File: rtl/split_route_two.sv
// split_route_two: one-input, two-output router for 4-phase bundled-data words.
// The top bit of each word selects which of two per-output FIFOs it enters.
// Each output has its own handshake engine. A stalled consumer therefore holds
// up only the words addressed to it, plus any word waiting behind them at the
// shared input.
module split_route_two #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    parameter int FL    = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_req,
    output logic             in_ack,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_req,
    input  logic             out0_ack,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_req,
    input  logic             out1_ack,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(FL + 1);

    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_SETUP, O_REQ, O_REL} out_state_t;

    in_state_t        in_state_q, in_state_d;
    logic             in_ack_q, in_ack_d;
    logic             dest;
    logic [1:0]       push;
    logic [1:0]       full;
    logic [1:0]       out_ack;
    logic [1:0]       out_req;
    logic [WIDTH-1:0] out_data  [2];
    logic [CNT_W-1:0] out_count [2];

    assign dest    = in_data[WIDTH-1];
    assign out_ack = {out1_ack, out0_ack};

    // Input handshake: accept a word when its FIFO has room, then wait for req to drop.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave
        // it unassigned and infer a latch.
        in_state_d = in_state_q;
        in_ack_d   = in_ack_q;
        push       = 2'b00;
        case (in_state_q)
            IN_IDLE: begin
                // The full flag is the pre-pop value; a pop this cycle frees its slot next cycle.
                if (in_req && !full[dest]) begin
                    push[dest] = 1'b1;
                    in_ack_d   = 1'b1;
                    in_state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!in_req) begin
                    in_ack_d   = 1'b0;
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    // Input state and acknowledge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values whatever order the blocks run in.
        if (!rst_n) begin
            in_state_q <= IN_IDLE;
            in_ack_q   <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            in_ack_q   <= in_ack_d;
        end
    end

    assign in_ack = in_ack_q;

    for (genvar g = 0; g < 2; g++) begin : g_out
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [PW:0]      occ;
        logic             empty;
        logic             pop;
        logic             done;
        out_state_t       state_q, state_d;
        logic [SW-1:0]    setup_q, setup_d;
        logic             req_q, req_d;
        logic [WIDTH-1:0] data_q;
        logic [CNT_W-1:0] count_q;

        assign full[g] = (occ == (PW+1)'(DEPTH));
        assign empty   = (occ == '0);

        // FIFO storage: written on push.
        always_ff @(posedge clk) begin
            // NOTE: the storage array has no reset; the cleared pointers and
            // occupancy already mark every entry as invalid.
            if (push[g]) begin
                mem[wr_ptr] <= in_data;
            end
        end

        // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push[g], pop})
                    2'b10:   occ <= occ + (PW+1)'(1);
                    2'b01:   occ <= occ - (PW+1)'(1);
                    default: occ <= occ;
                endcase
            end
        end

        // Output handshake: load the head word, hold it for FL cycles, then run a 4-phase cycle.
        always_comb begin
            state_d = state_q;
            setup_d = setup_q;
            req_d   = req_q;
            pop     = 1'b0;
            done    = 1'b0;
            case (state_q)
                O_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        setup_d = SW'(FL);
                        state_d = O_SETUP;
                    end
                end
                O_SETUP: begin
                    // An ack arriving here is a protocol error and is ignored.
                    if (setup_q == SW'(1)) begin
                        setup_d = '0;
                        req_d   = 1'b1;
                        state_d = O_REQ;
                    end else begin
                        setup_d = setup_q - SW'(1);
                    end
                end
                O_REQ: begin
                    if (out_ack[g]) begin
                        req_d   = 1'b0;
                        state_d = O_REL;
                    end
                end
                O_REL: begin
                    if (!out_ack[g]) begin
                        done    = 1'b1;
                        state_d = O_IDLE;
                    end
                end
                default: state_d = O_IDLE;
            endcase
        end

        // Output state, request, held data and completed-transfer counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= O_IDLE;
                setup_q <= '0;
                req_q   <= 1'b0;
                data_q  <= '0;
                count_q <= '0;
            end else begin
                state_q <= state_d;
                setup_q <= setup_d;
                req_q   <= req_d;
                if (pop) begin
                    data_q <= mem[rd_ptr];
                end
                if (done) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end

        assign out_req[g]   = req_q;
        assign out_data[g]  = data_q;
        assign out_count[g] = count_q;
    end

    assign out0_req  = out_req[0];
    assign out1_req  = out_req[1];
    assign out0_data = out_data[0];
    assign out1_data = out_data[1];
    assign count0    = out_count[0];
    assign count1    = out_count[1];

endmodule

// File: doc/split_route_two.md
Name: split_route_two

Overview:
- Counterpart of the two-input arbiter merge: a one-input, two-output router for 33-bit words on 4-phase bundled-data channels.
- Each incoming word is steered by its destination bit to output 0 or output 1.
- Each output has its own small FIFO, so a stalled output does not block the other while the head word targets a free output.
- Sits downstream of the merge. The merged stream is fanned back out to two consumers, e.g. data buckets or processing elements.

Parameters:
- WIDTH, 33, word width; bit WIDTH-1 is the destination bit; the full word is forwarded unchanged.
- DEPTH, 2, entries per output FIFO; power of two, >=2.
- FL, 1, cycles the output data is held stable before the output req rises; >=1.
- CNT_W, 16, width of the per-output completed-transfer counters.

Ports:
- clk  in  1  single clock; all handshake signals are synchronous to it.
- rst_n  in  1  reset, asynchronous assert, active low.
- in_req  in  1  input 4-phase request.
- in_ack  out  1  input 4-phase acknowledge.
- in_data  in  WIDTH  input bundled data; valid while in_req is high.
- out0_req  out  1  output 0 request.
- out0_ack  in  1  output 0 acknowledge.
- out0_data  out  WIDTH  output 0 data.
- out1_req  out  1  output 1 request.
- out1_ack  in  1  output 1 acknowledge.
- out1_data  out  WIDTH  output 1 data.
- count0  out  CNT_W  completed transfers on output 0.
- count1  out  CNT_W  completed transfers on output 1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - in_ack, out0_req and out1_req go to 0 immediately.
  - outN_data go to 0; count0/count1 go to 0.
  - Both FIFOs are emptied; all FSMs return to IDLE.
  - A reset mid-handshake abandons that word. The environment is reset with the block.
- Routing: dest = in_data[WIDTH-1]; 0 selects FIFO0, 1 selects FIFO1.
- Input FSM, states IN_IDLE and IN_ACK, all decisions registered:
  - IN_IDLE: on an edge where in_req=1 and FIFO[dest] is not full, push in_data to FIFO[dest], set in_ack=1 and go to IN_ACK.
  - If FIFO[dest] is full, in_ack stays 0 and nothing is pushed. Evaluation is retried every cycle; this is head-of-line blocking.
  - IN_ACK: on an edge with in_req=0, clear in_ack and go to IN_IDLE.
  - Latency: in_ack is visible 1 cycle after in_req is first sampled high with space available.
- Full flag: the full flag used for a push is that cycle's pre-pop value. A pop in the same cycle does not free a slot until the next cycle.
- Output FSM N (independent per output), states O_IDLE, O_SETUP, O_REQ, O_REL:
  - O_IDLE: if FIFON is non-empty, load outN_data from the head, pop, load the setup counter with FL, and go to O_SETUP.
  - O_SETUP: decrement the setup counter; when it reaches 0, set outN_req=1 and go to O_REQ.
  - O_REQ: on an edge with outN_ack=1, clear outN_req and go to O_REL.
  - O_REL: on an edge with outN_ack=0, increment countN and go to O_IDLE.
  - outN_data holds its value from the O_IDLE load through O_REL, and keeps it while idle.
  - Minimum latency, FL=1: a word pushed at edge k appears on outN_data after edge k+1; outN_req rises after edge k+2.
- FIFO: circular buffer with wrapping read/write pointers and an occupancy count of 0..DEPTH.
  - Simultaneous push and pop on the same FIFO is allowed. The count is unchanged and order is preserved.
- Counters wrap modulo 2^CNT_W with no saturation.
- outN_ack high while in O_IDLE or O_SETUP is a protocol error and is ignored.

Test Plan:
- Single word to output 0: send 0x0_0000_0005 with out0_ack responding.
  - out0_data=0x0_0000_0005; out0_req rises 2 cycles after in_ack.
  - count0=1, count1=0, out1_req never rises.
- Single word to output 1: send 0x1_0000_000A.
  - out1_data=0x1_0000_000A; count1=1, count0=0.
- Blocked output: hold out0_ack=0 and send five dest-0 words 1..5 (DEPTH=2).
  - The first three are accepted: one is in O_REQ, two are in FIFO0. in_ack stays 0 for word 4.
  - Release out0_ack: all five emerge in order 1..5 and count0=5.
- Independence: FIFO0 is full and stalled, and a dest-1 word arrives while the input is idle.
  - The dest-1 word is acknowledged and delivered on output 1.
  - A dest-0 word at the input head blocks until output 0 drains.
- Random mixed traffic: 30 words with random dest bits and random ack delays of 0–5 cycles.
  - Each output's sequence equals the input sequence filtered by dest.
  - count0+count1=30; no data change while outN_req=1.
- Reset mid-transfer: assert rst_n=0 while out1_req=1 and FIFO0 holds 2 words.
  - All reqs/acks and counts are 0 immediately.
  - After release, a new word 0x0_0000_0003 is delivered as the first output-0 word.
